// File: rtl/nonogram_pkg.sv
// Shared constants and types for the nonogram solver datapath.
// Board geometry, index widths and the solution assembler state encoding.
package nonogram_pkg;

    localparam int MAX_ROWS        = 11;
    localparam int MAX_COLS        = 11;
    localparam int LARGEST_DIM     = (MAX_ROWS > MAX_COLS) ? MAX_ROWS : MAX_COLS;
    localparam int MAX_NUM_OPTIONS = 1 << LARGEST_DIM;

    localparam int BOARD_W = MAX_ROWS * MAX_COLS;
    localparam int ROW_W   = $clog2(MAX_ROWS);
    localparam int COL_W   = $clog2(MAX_COLS);
    localparam int WORD_W  = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_WAIT   = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    // Oversized counts from the solver saturate at the board limits.
    function automatic logic [ROW_W-1:0] clamp_rows(input logic [ROW_W-1:0] v);
        return (int'(v) > MAX_ROWS) ? ROW_W'(MAX_ROWS) : v;
    endfunction

    function automatic logic [COL_W-1:0] clamp_cols(input logic [COL_W-1:0] v);
        return (int'(v) > MAX_COLS) ? COL_W'(MAX_COLS) : v;
    endfunction

endpackage

// File: rtl/solution_assembler_if.sv
// Board-in / byte-out bus of the solution assembler, plus a state debug tap.
// Handshake: valid_in is a one-cycle board pulse taken only in IDLE; send marks one
// outstanding byte that no further send may follow until a transmit_done pulse.
interface solution_assembler_if;
    import nonogram_pkg::*;

    logic               valid_in;
    logic               transmit_done;
    logic [BOARD_W-1:0] solution;
    logic [COL_W-1:0]   n;
    logic [ROW_W-1:0]   m;
    logic               send;
    logic [7:0]         byte_out;
    logic               done;
    state_t             dbg_state;

    modport master (
        output valid_in, transmit_done, solution, n, m,
        input  send, byte_out, done, dbg_state
    );

    modport slave (
        input  valid_in, transmit_done, solution, n, m,
        output send, byte_out, done, dbg_state
    );

endinterface

// File: rtl/solution_assembler_row_extract.sv
// Combinational row slicer: picks row r out of the flat board and zeroes
// every column at or beyond n, giving a 16-bit word with column c at bit c.
module row_extract
    import nonogram_pkg::*;
(
    input  logic [BOARD_W-1:0] i_board,
    input  logic [ROW_W-1:0]   i_row,
    input  logic [COL_W-1:0]   i_n,
    output logic [WORD_W-1:0]  o_word
);

    localparam int IDX_W = $clog2(BOARD_W);

    logic [IDX_W-1:0] w_idx;

    always_comb begin
        o_word = '0;
        w_idx  = '0;
        for (int c = 0; c < MAX_COLS; c++) begin
            w_idx = IDX_W'(int'(i_row) * MAX_COLS + c);
            if (COL_W'(c) < i_n && int'(i_row) < MAX_ROWS) begin
                o_word[c] = i_board[w_idx];
            end
        end
    end

endmodule

// File: rtl/solution_assembler.sv
// Serialises a latched nonogram board as two bytes per row (high then low half)
// towards a UART transmitter, pulsing done once the last byte has completed.
module solution_assembler
    import nonogram_pkg::*;
(
    input  logic clk,
    input  logic rst,
    solution_assembler_if.slave bus
);

    state_t             r_state, w_state;
    logic [BOARD_W-1:0] r_board, w_board;
    logic [ROW_W-1:0]   r_m, w_m;
    logic [COL_W-1:0]   r_n, w_n;
    logic [ROW_W-1:0]   r_row, w_row;
    logic               r_phase, w_phase;
    logic               r_send, w_send;
    logic               r_done, w_done;
    logic [7:0]         r_byte, w_byte;

    logic [WORD_W-1:0]  w_word;
    logic [ROW_W-1:0]   w_m_clamped;
    logic [COL_W-1:0]   w_n_clamped;

    row_extract u_row_extract (
        .i_board (r_board),
        .i_row   (r_row),
        .i_n     (r_n),
        .o_word  (w_word)
    );

    assign w_m_clamped = clamp_rows(bus.m);
    assign w_n_clamped = clamp_cols(bus.n);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_board <= '0;
            r_m     <= '0;
            r_n     <= '0;
            r_row   <= '0;
            r_phase <= 1'b0;
            r_send  <= 1'b0;
            r_done  <= 1'b0;
            r_byte  <= '0;
        end else begin
            r_state <= w_state;
            r_board <= w_board;
            r_m     <= w_m;
            r_n     <= w_n;
            r_row   <= w_row;
            r_phase <= w_phase;
            r_send  <= w_send;
            r_done  <= w_done;
            r_byte  <= w_byte;
        end
    end

    // Outputs are registered, so send/done appear one cycle after LOAD/FINISH.
    always_comb begin
        w_state = r_state;
        w_board = r_board;
        w_m     = r_m;
        w_n     = r_n;
        w_row   = r_row;
        w_phase = r_phase;
        w_send  = 1'b0;
        w_done  = 1'b0;
        w_byte  = r_byte;

        case (r_state)
            S_IDLE: begin
                if (bus.valid_in) begin
                    w_board = bus.solution;
                    w_m     = w_m_clamped;
                    w_n     = w_n_clamped;
                    w_row   = '0;
                    w_phase = 1'b0;
                    if (w_m_clamped == '0 || w_n_clamped == '0) begin
                        w_state = S_FINISH;
                    end else begin
                        w_state = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                w_send  = 1'b1;
                w_byte  = r_phase ? w_word[7:0] : w_word[15:8];
                w_state = S_WAIT;
            end
            S_WAIT: begin
                if (bus.transmit_done) begin
                    if (!r_phase) begin
                        w_phase = 1'b1;
                        w_state = S_LOAD;
                    end else if (r_row < (r_m - 1'b1)) begin
                        w_row   = r_row + 1'b1;
                        w_phase = 1'b0;
                        w_state = S_LOAD;
                    end else begin
                        w_state = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                w_done  = 1'b1;
                w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign bus.send      = r_send;
    assign bus.done      = r_done;
    assign bus.byte_out  = r_byte;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_solution_assembler.sv
// Self-checking bench for solution_assembler: random boards and handshake delays
// compared against a row/column arithmetic model of the expected byte stream.
module tb_solution_assembler;
    import nonogram_pkg::*;

    logic clk;
    logic rst;
    solution_assembler_if bus ();

    solution_assembler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int  obs_bad;
    int  obs_first_lat;
    int  obs_done_lat;
    bit  obs_got_done;
    bit  obs_timeout;
    bit  obs_done_width_ok;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: each row is the sum of its filled columns below n, split high/low.
    function automatic void build_expected(input logic [BOARD_W-1:0] sol, input int m_in, input int n_in);
        int mm;
        int nn;
        int word;
        mm = (m_in > MAX_ROWS) ? MAX_ROWS : m_in;
        nn = (n_in > MAX_COLS) ? MAX_COLS : n_in;
        exp_q.delete();
        if (mm == 0 || nn == 0) return;
        for (int r = 0; r < mm; r++) begin
            word = 0;
            for (int c = 0; c < nn; c++) begin
                if (sol[r * MAX_COLS + c]) word = word + (1 << c);
            end
            exp_q.push_back(8'(word / 256));
            exp_q.push_back(8'(word % 256));
        end
    endfunction

    function automatic logic [BOARD_W-1:0] rand_board();
        logic [BOARD_W-1:0] b;
        for (int i = 0; i < BOARD_W; i++) b[i] = 1'($urandom_range(1, 0));
        return b;
    endfunction

    // Plays solver + uart_tx: pulses valid_in, answers each send after a random delay.
    task automatic drive_board(input logic [BOARD_W-1:0] sol, input logic [3:0] mm, input logic [3:0] nn,
                               input int dly_lo, input int dly_hi, input int stop_after,
                               input bit spurious, input int revalid_after, input logic [BOARD_W-1:0] alt_sol);
        int cyc;
        int last_ev;
        int wait_left;
        int sends;
        bit outstanding;
        bit revalid_done;
        obs_q.delete();
        obs_bad = 0;
        obs_first_lat = -1;
        obs_done_lat = -1;
        obs_got_done = 0;
        obs_timeout = 0;
        obs_done_width_ok = 1;
        sends = 0;
        outstanding = 0;
        wait_left = 0;
        last_ev = 0;
        revalid_done = 0;
        bus.solution = sol;
        bus.m = mm;
        bus.n = nn;
        bus.valid_in = 1'b1;
        tick();
        cyc = 1;
        while (!obs_got_done && cyc < 4000) begin
            bus.transmit_done = 1'b0;
            bus.valid_in = 1'b0;
            if (bus.send) begin
                if (outstanding || bus.done) obs_bad++;
                obs_q.push_back(bus.byte_out);
                if (sends == 0) obs_first_lat = cyc;
                sends++;
                outstanding = 1;
                wait_left = $urandom_range(dly_hi, dly_lo);
                if (stop_after > 0 && sends == stop_after) break;
            end
            if (bus.done) begin
                obs_got_done = 1;
                obs_done_lat = cyc - last_ev;
            end
            if (outstanding) begin
                if (wait_left == 0) begin
                    bus.transmit_done = 1'b1;
                    outstanding = 0;
                    last_ev = cyc;
                end else begin
                    wait_left--;
                end
            end else if (spurious && $urandom_range(3, 0) == 0) begin
                bus.transmit_done = 1'b1;
            end
            if (revalid_after > 0 && !revalid_done && sends == revalid_after && !obs_got_done) begin
                bus.solution = alt_sol;
                bus.m = 4'd11;
                bus.n = 4'd11;
                bus.valid_in = 1'b1;
                revalid_done = 1;
            end
            if (!obs_got_done) begin
                tick();
                cyc++;
            end
        end
        if (obs_got_done) begin
            tick();
            obs_done_width_ok = !bus.done && !bus.send;
        end
        bus.transmit_done = 1'b0;
        bus.valid_in = 1'b0;
        if (!obs_got_done && stop_after == 0) obs_timeout = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (bus.send !== 1'b0) begin failures++; $display("FAIL reset_send got=%b exp=0", bus.send); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        checks++; if (bus.byte_out !== 8'h00) begin failures++; $display("FAIL reset_byte got=%02h exp=00", bus.byte_out); end
        checks++; if (bus.dbg_state !== S_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", bus.dbg_state, S_IDLE); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_board();
        logic [BOARD_W-1:0] sol;
        sol = '1;
        build_expected(sol, 11, 11);
        drive_board(sol, 4'd11, 4'd11, 0, 3, 0, 1'b1, 0, '0);
        checks++; if (obs_timeout) begin failures++; $display("FAIL full_timeout got=no_done exp=done"); end
        checks++; if (obs_q.size() != 22) begin failures++; $display("FAIL full_count got=%0d exp=22", obs_q.size()); end
        foreach (obs_q[i]) begin
            checks++;
            if (obs_q[i] !== ((i % 2 == 0) ? 8'h07 : 8'hFF)) begin
                failures++; $display("FAIL full_byte%0d got=%02h exp=%02h", i, obs_q[i], (i % 2 == 0) ? 8'h07 : 8'hFF);
            end
        end
        checks++; if (obs_first_lat != 2) begin failures++; $display("FAIL full_first_latency got=%0d exp=2", obs_first_lat); end
        checks++; if (obs_done_lat < 1 || obs_done_lat > 2) begin failures++; $display("FAIL full_done_latency got=%0d exp=1..2", obs_done_lat); end
        checks++; if (!obs_done_width_ok) begin failures++; $display("FAIL full_done_width got=long exp=one_cycle"); end
        checks++; if (obs_bad != 0) begin failures++; $display("FAIL full_overlap got=%0d exp=0", obs_bad); end
    endtask

    task automatic test_small_board();
        logic [BOARD_W-1:0] sol;
        logic [7:0] lit_q[$];
        sol = '0;
        sol[0] = 1'b1;
        sol[4] = 1'b1;
        for (int c = 5; c < MAX_COLS; c++) sol[c] = 1'b1;
        sol[MAX_COLS + 7] = 1'b1;
        sol[MAX_COLS + 10] = 1'b1;
        for (int c = 0; c < MAX_COLS; c++) sol[2 * MAX_COLS + c] = 1'b1;
        for (int c = 0; c < MAX_COLS; c++) sol[5 * MAX_COLS + c] = 1'b1;
        lit_q = '{8'h00, 8'h11, 8'h00, 8'h00, 8'h00, 8'h1F};
        drive_board(sol, 4'd3, 4'd5, 0, 2, 0, 1'b0, 0, '0);
        checks++; if (obs_q.size() != lit_q.size()) begin failures++; $display("FAIL small_count got=%0d exp=%0d", obs_q.size(), lit_q.size()); end
        foreach (lit_q[i]) if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== lit_q[i]) begin failures++; $display("FAIL small_byte%0d got=%02h exp=%02h", i, obs_q[i], lit_q[i]); end
        end
        checks++; if (!obs_got_done) begin failures++; $display("FAIL small_done got=none exp=pulse"); end
    endtask

    task automatic test_handshake();
        logic [BOARD_W-1:0] sol;
        int idle_bad;
        idle_bad = 0;
        for (int i = 0; i < 6; i++) begin
            bus.transmit_done = (i % 2 == 0);
            tick();
            if (bus.send || bus.done || bus.dbg_state != S_IDLE) idle_bad++;
        end
        bus.transmit_done = 1'b0;
        checks++; if (idle_bad != 0) begin failures++; $display("FAIL idle_spurious got=%0d exp=0", idle_bad); end
        sol = rand_board();
        build_expected(sol, 3, 9);
        drive_board(sol, 4'd3, 4'd9, 100, 100, 0, 1'b1, 0, '0);
        checks++; if (obs_timeout) begin failures++; $display("FAIL hs_timeout got=no_done exp=done"); end
        checks++; if (obs_bad != 0) begin failures++; $display("FAIL hs_overlap got=%0d exp=0", obs_bad); end
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL hs_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL hs_byte%0d got=%02h exp=%02h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_revalid();
        logic [BOARD_W-1:0] sol;
        sol = rand_board();
        build_expected(sol, 4, 9);
        drive_board(sol, 4'd4, 4'd9, 0, 3, 0, 1'b0, 2, '1);
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL reval_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL reval_byte%0d got=%02h exp=%02h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (!obs_done_width_ok) begin failures++; $display("FAIL reval_after_done got=busy exp=idle"); end
    endtask

    task automatic test_reset_mid();
        logic [BOARD_W-1:0] sol;
        int quiet_bad;
        sol = rand_board();
        drive_board(sol, 4'd5, 4'd11, 0, 2, 3, 1'b0, 0, '0);
        checks++; if (obs_q.size() != 3) begin failures++; $display("FAIL abort_pre_count got=%0d exp=3", obs_q.size()); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.send !== 1'b0) begin failures++; $display("FAIL abort_send got=%b exp=0", bus.send); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", bus.done); end
        checks++; if (bus.byte_out !== 8'h00) begin failures++; $display("FAIL abort_byte got=%02h exp=00", bus.byte_out); end
        quiet_bad = 0;
        for (int i = 0; i < 8; i++) begin
            bus.transmit_done = (i == 1);
            tick();
            if (bus.send || bus.done) quiet_bad++;
        end
        bus.transmit_done = 1'b0;
        checks++; if (quiet_bad != 0) begin failures++; $display("FAIL abort_quiet got=%0d exp=0", quiet_bad); end
        sol = rand_board();
        build_expected(sol, 2, 7);
        drive_board(sol, 4'd2, 4'd7, 0, 2, 0, 1'b0, 0, '0);
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL restart_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL restart_byte%0d got=%02h exp=%02h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_clamp();
        logic [BOARD_W-1:0] sol;
        sol = rand_board();
        drive_board(sol, 4'd0, 4'd5, 0, 0, 0, 1'b0, 0, '0);
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL m0_sends got=%0d exp=0", obs_q.size()); end
        checks++; if (obs_done_lat != 2) begin failures++; $display("FAIL m0_done_latency got=%0d exp=2", obs_done_lat); end
        drive_board(sol, 4'd3, 4'd0, 0, 0, 0, 1'b0, 0, '0);
        checks++; if (obs_q.size() != 0 || !obs_got_done) begin failures++; $display("FAIL n0 got_sends=%0d got_done=%0d exp_sends=0 exp_done=1", obs_q.size(), obs_got_done); end
        build_expected(sol, 15, 11);
        drive_board(sol, 4'd15, 4'd11, 0, 2, 0, 1'b0, 0, '0);
        checks++; if (obs_q.size() != 22) begin failures++; $display("FAIL m15_count got=%0d exp=22", obs_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL m15_byte%0d got=%02h exp=%02h", i, obs_q[i], exp_q[i]); end
        end
        build_expected(sol, 2, 15);
        drive_board(sol, 4'd2, 4'd15, 0, 2, 0, 1'b0, 0, '0);
        checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL n15_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL n15_byte%0d got=%02h exp=%02h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        logic [BOARD_W-1:0] sol;
        int mm;
        int nn;
        for (int t = 0; t < 10; t++) begin
            sol = rand_board();
            mm = $urandom_range(15, 0);
            nn = $urandom_range(15, 0);
            build_expected(sol, mm, nn);
            drive_board(sol, 4'(mm), 4'(nn), 0, 4, 0, 1'b1, 0, '0);
            checks++; if (obs_timeout || obs_bad != 0) begin failures++; $display("FAIL rand%0d_protocol got_timeout=%0d got_overlap=%0d exp=0/0", t, obs_timeout, obs_bad); end
            checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rand%0d_count m=%0d n=%0d got=%0d exp=%0d", t, mm, nn, obs_q.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < obs_q.size()) begin
                checks++; if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rand%0d_byte%0d got=%02h exp=%02h", t, i, obs_q[i], exp_q[i]); end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.valid_in = 1'b0;
        bus.transmit_done = 1'b0;
        bus.solution = '0;
        bus.m = '0;
        bus.n = '0;
        test_reset();
        test_full_board();
        test_small_board();
        test_handshake();
        test_revalid();
        test_reset_mid();
        test_clamp();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
